spike_rate_encoder: RTL and testbench

- Upstream stage of the spiking network: converts a vector of pixel intensities into Poisson-like (rate-coded) spike trains for a fixed number of timesteps.
- Each input channel compares a per-channel LFSR sample against its latched intensity, so spike probability is proportional to intensity.
- Produces one registered spike bit per network input per cycle, plus a valid strobe and an end-of-image pulse.

---
 rtl/snn_encoder_pkg.sv | 29 ++
 rtl/spike_rate_encoder_if.sv | 23 ++
 rtl/snn_lfsr.sv | 23 ++
 rtl/spike_rate_encoder.sv | 160 ++++++++++++++++
 tb/tb_spike_rate_encoder.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_encoder_pkg.sv
// Shared types and helpers for the spike rate encoder: FSM state encoding,
// LFSR geometry and per-channel seed derivation.
package snn_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    localparam int unsigned LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

    // Channel i seed is the base seed XOR (i+1); callers keep it nonzero.
    function automatic logic [LFSR_WIDTH-1:0] channel_seed(
        input logic [LFSR_WIDTH-1:0] base,
        input int unsigned           idx
    );
        return base ^ LFSR_WIDTH'(idx + 1);
    endfunction

    // One step of a right-shifting Galois LFSR.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(
        input logic [LFSR_WIDTH-1:0] v
    );
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Image handshake between the pixel source and the spike rate encoder.
interface spike_rate_encoder_if #(
    parameter int unsigned NUM_INPUTS  = 1,
    parameter int unsigned PIXEL_WIDTH = 8
);

    logic                              pixel_valid;
    logic                              pixel_ready;
    logic [NUM_INPUTS*PIXEL_WIDTH-1:0] pixel_data;

    modport master (
        output pixel_valid,
        output pixel_data,
        input  pixel_ready
    );

    modport slave (
        input  pixel_valid,
        input  pixel_data,
        output pixel_ready
    );

endinterface

// File: rtl/snn_lfsr.sv
// 16-bit Galois LFSR (taps 16'hB400, shift right) that steps only when
// advance is high and reloads its seed on reset.
module snn_lfsr
    import snn_encoder_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    output logic [LFSR_WIDTH-1:0] value
);

    // Seed on reset, otherwise step once per advance cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-coded spike encoder: latches an image of NUM_INPUTS intensities and
// emits NUM_TIMESTEPS registered spike vectors, where channel i spikes when
// its LFSR sample is below its intensity, followed by a one-cycle done pulse.
// Optional macro SPIKE_ENCODER_COUNT_EN adds per-channel spike counters on
// the spike_count port.
module spike_rate_encoder
    import snn_encoder_pkg::*;
#(
    parameter int unsigned     NUM_INPUTS    = 1,
    parameter int unsigned     PIXEL_WIDTH   = 8,
    parameter int unsigned     NUM_TIMESTEPS = 32,
    parameter logic [15:0]     LFSR_SEED     = 16'hACE1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    spike_rate_encoder_if.slave                   pixel,
    output logic [NUM_INPUTS-1:0]                 spike_out,
    output logic                                  spike_valid,
    output logic [$clog2(NUM_TIMESTEPS+1)-1:0]    timestep,
    output logic                                  done
`ifdef SPIKE_ENCODER_COUNT_EN
    ,
    output logic [NUM_INPUTS*$clog2(NUM_TIMESTEPS+1)-1:0] spike_count
`endif
);

    localparam int unsigned TW = $clog2(NUM_TIMESTEPS + 1);

    enc_state_t state;
    enc_state_t state_next;

    logic [NUM_INPUTS*PIXEL_WIDTH-1:0] pix_q;
    logic [TW-1:0]                     step_q;
    logic                              ready_q;
    logic                              accept;
    logic                              running;
    logic                              last_step;

    logic [LFSR_WIDTH-1:0]             lfsr_val [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]             unused_lfsr;
    logic [NUM_INPUTS-1:0]             spike_cmp;

    logic [NUM_INPUTS-1:0]             spike_d;
    logic                              valid_d;
    logic                              done_d;
    logic                              ready_d;

    assign pixel.pixel_ready = ready_q;
    assign accept            = (state == IDLE) && pixel.pixel_valid && ready_q;
    assign running           = (state == RUN);
    assign last_step         = (step_q == TW'(NUM_TIMESTEPS - 1));

    // One free-running-in-RUN LFSR per channel, each with its own seed.
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lfsr
        snn_lfsr #(
            .SEED(channel_seed(LFSR_SEED, g))
        ) u_lfsr (
            .clk     (clk),
            .rst     (rst),
            .advance (running),
            .value   (lfsr_val[g])
        );
        // Only the low PIXEL_WIDTH bits feed the comparator.
        assign unused_lfsr[g] = ^lfsr_val[g];
    end

    // Per-channel unsigned strict less-than of LFSR sample against intensity.
    always_comb begin
        spike_cmp = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            spike_cmp[i] = lfsr_val[i][PIXEL_WIDTH-1:0] < pix_q[i*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN for NUM_TIMESTEPS cycles, one DONE cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs for the current state.
    always_comb begin
        spike_d = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        ready_d = (state_next == IDLE);
        unique case (state)
            RUN: begin
                spike_d = spike_cmp;
                valid_d = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Registered outputs; ready is registered from the next state so an image
    // can be taken on the edge right after the done pulse is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_out   <= '0;
            spike_valid <= 1'b0;
            done        <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            spike_out   <= spike_d;
            spike_valid <= valid_d;
            done        <= done_d;
            ready_q     <= ready_d;
        end
    end

    // Image latch and timestep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q    <= '0;
            step_q   <= '0;
            timestep <= '0;
        end else if (accept) begin
            pix_q  <= pixel.pixel_data;
            step_q <= '0;
        end else if (running) begin
            timestep <= step_q;
            step_q   <= last_step ? '0 : step_q + TW'(1);
        end
    end

`ifdef SPIKE_ENCODER_COUNT_EN
    // Per-channel spike counters: cleared at accept, count every registered spike.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            spike_count <= '0;
        end else if (running) begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                if (spike_cmp[i]) begin
                    spike_count[i*TW +: TW] <= spike_count[i*TW +: TW] + TW'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder: scoreboard of expected spike
// vectors built from an independent LFSR model, one task per scenario.
module tb_spike_rate_encoder;

    localparam int NI  = 4;
    localparam int PW  = 8;
    localparam int NT  = 32;
    localparam int TWA = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spike_rate_encoder_if #(.NUM_INPUTS(NI), .PIXEL_WIDTH(PW)) bus_a ();
    spike_rate_encoder_if #(.NUM_INPUTS(1),  .PIXEL_WIDTH(PW)) bus_b ();

    logic [NI-1:0]  spike_a;
    logic           sv_a;
    logic [TWA-1:0] ts_a;
    logic           done_a;
    logic           spike_b;
    logic           sv_b;
    logic [0:0]     ts_b;
    logic           done_b;
`ifdef SPIKE_ENCODER_COUNT_EN
    logic [NI*TWA-1:0] cnt_a;
    logic [0:0]        cnt_b;
`endif

    spike_rate_encoder #(
        .NUM_INPUTS(NI), .PIXEL_WIDTH(PW), .NUM_TIMESTEPS(NT), .LFSR_SEED(16'hACE1)
    ) dut_a (
        .clk(clk), .rst(rst), .pixel(bus_a),
        .spike_out(spike_a), .spike_valid(sv_a), .timestep(ts_a), .done(done_a)
`ifdef SPIKE_ENCODER_COUNT_EN
        , .spike_count(cnt_a)
`endif
    );

    spike_rate_encoder #(
        .NUM_INPUTS(1), .PIXEL_WIDTH(PW), .NUM_TIMESTEPS(1), .LFSR_SEED(16'hACE1)
    ) dut_b (
        .clk(clk), .rst(rst), .pixel(bus_b),
        .spike_out(spike_b), .spike_valid(sv_b), .timestep(ts_b), .done(done_b)
`ifdef SPIKE_ENCODER_COUNT_EN
        , .spike_count(cnt_b)
`endif
    );

    typedef struct {
        logic [NI-1:0]  spk;
        logic [TWA-1:0] ts;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_lfsr[NI];
    logic [15:0] m_b;

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        logic [15:0] n;
        n = {1'b0, v[15:1]};
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) m_lfsr[i] = 16'hACE1 ^ 16'(i + 1);
        m_b = 16'hACE1 ^ 16'h0001;
    endtask

    task automatic push_image_a(input logic [NI*PW-1:0] px);
        exp_t e;
        for (int k = 0; k < NT; k++) begin
            e.ts = TWA'(k);
            for (int i = 0; i < NI; i++) begin
                e.spk[i]  = (m_lfsr[i][7:0] < px[i*PW +: PW]);
                m_lfsr[i] = ref_step(m_lfsr[i]);
            end
            sb.push_back(e);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus_a.pixel_valid = 1'b0;
        bus_b.pixel_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (bus_a.pixel_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_a: got %b expected 1", bus_a.pixel_ready); end
        n_checks++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %b expected 0", sv_a); end
        n_checks++; if (spike_a !== '0) begin n_fail++; $display("FAIL reset_spike_a: got %h expected 0", spike_a); end
        n_checks++; if (ts_a !== '0) begin n_fail++; $display("FAIL reset_timestep_a: got %0d expected 0", ts_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done_a: got %b expected 0", done_a); end
        n_checks++; if (bus_b.pixel_ready !== 1'b1 || sv_b !== 1'b0 || done_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_b: got ready=%b valid=%b done=%b expected 1 0 0", bus_b.pixel_ready, sv_b, done_b);
        end
`ifdef SPIKE_ENCODER_COUNT_EN
        n_checks++; if (cnt_a !== '0) begin n_fail++; $display("FAIL reset_count_a: got %h expected 0", cnt_a); end
`endif
    endtask

    task automatic test_zero_pix();
        exp_t e;
        n_checks++; if (bus_a.pixel_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready_pre: got %b expected 1", bus_a.pixel_ready); end
        bus_a.pixel_data  = '0;
        bus_a.pixel_valid = 1'b1;
        @(posedge clk);
        push_image_a('0);
        @(negedge clk);
        bus_a.pixel_valid = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (sv_a !== (c <= NT)) begin n_fail++; $display("FAIL zero_valid c=%0d: got %b expected %b", c, sv_a, (c <= NT)); end
            n_checks++; if (spike_a !== '0) begin n_fail++; $display("FAIL zero_spike c=%0d: got %h expected 0", c, spike_a); end
            n_checks++; if (done_a !== (c == NT + 1)) begin n_fail++; $display("FAIL zero_done c=%0d: got %b expected %b", c, done_a, (c == NT + 1)); end
            if (c <= NT) begin
                n_checks++; if (ts_a !== TWA'(c - 1)) begin n_fail++; $display("FAIL zero_timestep c=%0d: got %0d expected %0d", c, ts_a, c - 1); end
                n_checks++; if (bus_a.pixel_ready !== 1'b0) begin n_fail++; $display("FAIL zero_ready_run c=%0d: got %b expected 0", c, bus_a.pixel_ready); end
            end
            if (c >= NT + 2) begin
                n_checks++; if (bus_a.pixel_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready_idle c=%0d: got %b expected 1", c, bus_a.pixel_ready); end
            end
            if (sv_a === 1'b1 && sb.size() > 0) e = sb.pop_front();
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL zero_sb_left: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_mixed();
        exp_t e;
        logic [NI*PW-1:0] img;
        img = {8'd0, 8'd16, 8'd128, 8'd255};
        n_checks++; if (bus_a.pixel_ready !== 1'b1) begin n_fail++; $display("FAIL mixed_ready_pre: got %b expected 1", bus_a.pixel_ready); end
        bus_a.pixel_data  = img;
        bus_a.pixel_valid = 1'b1;
        @(posedge clk);
        push_image_a(img);
        @(negedge clk);
        bus_a.pixel_data = 32'h5A5A5A5A;
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (sv_a === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL mixed_unexpected c=%0d: got spike_valid 1 expected 0", c);
                end else begin
                    e = sb.pop_front();
                    if (spike_a !== e.spk || ts_a !== e.ts) begin
                        n_fail++; $display("FAIL mixed_spike c=%0d: got %b/%0d expected %b/%0d", c, spike_a, ts_a, e.spk, e.ts);
                    end
                end
                n_checks++; if (spike_a[3] !== 1'b0) begin n_fail++; $display("FAIL mixed_ch3 c=%0d: got 1 expected 0", c); end
            end else if (c <= NT) begin
                n_checks++; n_fail++; $display("FAIL mixed_missing c=%0d: got spike_valid %b expected 1", c, sv_a);
            end
            n_checks++; if (done_a !== (c == NT + 1)) begin n_fail++; $display("FAIL mixed_done c=%0d: got %b expected %b", c, done_a, (c == NT + 1)); end
            // Offer new data while busy; it must be ignored.
            bus_a.pixel_valid = (c < 20);
            bus_a.pixel_data  = $urandom;
        end
        bus_a.pixel_valid = 1'b0;
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL mixed_sb_left: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [NI*PW-1:0] img1, img2;
        logic go;
        int n_acc;
        int acc_at[2];
        img1 = 32'h40C02010;
        img2 = 32'hFF7F0180;
        n_acc = 0;
        acc_at[0] = 0;
        acc_at[1] = 0;
        bus_a.pixel_data  = img1;
        bus_a.pixel_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            go = bus_a.pixel_ready && bus_a.pixel_valid;
            @(posedge clk);
            if (go) begin
                if (n_acc < 2) acc_at[n_acc] = c;
                push_image_a(n_acc == 0 ? img1 : img2);
                n_acc++;
            end
            @(negedge clk);
            if (sv_a === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected c=%0d: got spike_valid 1 expected 0", c);
                end else begin
                    e = sb.pop_front();
                    if (spike_a !== e.spk || ts_a !== e.ts) begin
                        n_fail++; $display("FAIL b2b_spike c=%0d: got %b/%0d expected %b/%0d", c, spike_a, ts_a, e.spk, e.ts);
                    end
                end
                n_checks++; if (bus_a.pixel_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_run c=%0d: got 1 expected 0", c); end
            end
            if (n_acc == 1) bus_a.pixel_data = img2;
            else if (n_acc >= 2) bus_a.pixel_valid = 1'b0;
        end
        bus_a.pixel_valid = 1'b0;
        n_checks++; if (n_acc != 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", n_acc); end
        n_checks++; if (acc_at[1] - acc_at[0] != NT + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", acc_at[1] - acc_at[0], NT + 2); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_sb_left: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        logic [NI*PW-1:0] img;
        logic [NI-1:0] first[11];
        logic hit;
        img = {8'd77, 8'd200, 8'd33, 8'd150};
        apply_reset();
        for (int run = 0; run < 2; run++) begin
            bus_a.pixel_data  = img;
            bus_a.pixel_valid = 1'b1;
            @(posedge clk);
            push_image_a(img);
            @(negedge clk);
            bus_a.pixel_valid = 1'b0;
            hit = 1'b0;
            for (int c = 1; c <= 35 && !(run == 0 && hit); c++) begin
                @(posedge clk);
                @(negedge clk);
                if (sv_a === 1'b1) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++; $display("FAIL rstmid_unexpected run=%0d c=%0d: got spike_valid 1 expected 0", run, c);
                    end else begin
                        e = sb.pop_front();
                        if (spike_a !== e.spk || ts_a !== e.ts) begin
                            n_fail++; $display("FAIL rstmid_spike run=%0d c=%0d: got %b/%0d expected %b/%0d", run, c, spike_a, ts_a, e.spk, e.ts);
                        end
                    end
                    if (ts_a <= TWA'(10)) begin
                        if (run == 0) begin
                            first[ts_a] = spike_a;
                        end else begin
                            n_checks++; if (spike_a !== first[ts_a]) begin n_fail++; $display("FAIL rstmid_repeat ts=%0d: got %b expected %b", ts_a, spike_a, first[ts_a]); end
                        end
                    end
                    if (ts_a == TWA'(10)) hit = 1'b1;
                end
            end
            if (run == 0) begin
                n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach10: got 0 expected 1"); end
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                n_checks++; if (bus_a.pixel_ready !== 1'b1 || sv_a !== 1'b0 || spike_a !== '0 || ts_a !== '0 || done_a !== 1'b0) begin
                    n_fail++; $display("FAIL rstmid_outputs: got ready=%b valid=%b spike=%h ts=%0d done=%b expected 1 0 0 0 0", bus_a.pixel_ready, sv_a, spike_a, ts_a, done_a);
                end
                sb.delete();
                model_reset();
            end
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rstmid_sb_left: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_nt1();
        logic exp_spk;
        for (int img = 0; img < 2; img++) begin
            n_checks++; if (bus_b.pixel_ready !== 1'b1) begin n_fail++; $display("FAIL nt1_ready_pre img=%0d: got %b expected 1", img, bus_b.pixel_ready); end
            bus_b.pixel_data  = 8'd200;
            bus_b.pixel_valid = 1'b1;
            @(posedge clk);
            exp_spk = (m_b[7:0] < 8'd200);
            m_b = ref_step(m_b);
            @(negedge clk);
            bus_b.pixel_valid = 1'b0;
            n_checks++; if (sv_b !== 1'b0) begin n_fail++; $display("FAIL nt1_valid_T img=%0d: got %b expected 0", img, sv_b); end
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (sv_b !== 1'b1 || spike_b !== exp_spk || ts_b !== 1'b0 || done_b !== 1'b0) begin
                n_fail++; $display("FAIL nt1_T1 img=%0d: got valid=%b spike=%b ts=%0d done=%b expected 1 %b 0 0", img, sv_b, spike_b, ts_b, done_b, exp_spk);
            end
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (sv_b !== 1'b0 || done_b !== 1'b1 || spike_b !== 1'b0) begin
                n_fail++; $display("FAIL nt1_T2 img=%0d: got valid=%b done=%b spike=%b expected 0 1 0", img, sv_b, done_b, spike_b);
            end
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (done_b !== 1'b0 || bus_b.pixel_ready !== 1'b1) begin
                n_fail++; $display("FAIL nt1_T3 img=%0d: got done=%b ready=%b expected 0 1", img, done_b, bus_b.pixel_ready);
            end
        end
    endtask

`ifdef SPIKE_ENCODER_COUNT_EN
    task automatic test_count();
        exp_t e;
        int obs[NI];
        int mdl[NI];
        for (int i = 0; i < NI; i++) begin obs[i] = 0; mdl[i] = 0; end
        bus_a.pixel_data  = 32'h80808080;
        bus_a.pixel_valid = 1'b1;
        @(posedge clk);
        push_image_a(32'h80808080);
        @(negedge clk);
        bus_a.pixel_valid = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (sv_a === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < NI; i++) begin
                    obs[i] += int'(spike_a[i]);
                    mdl[i] += int'(e.spk[i]);
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++; if (cnt_a[i*TWA +: TWA] !== TWA'(obs[i]) || cnt_a[i*TWA +: TWA] !== TWA'(mdl[i])) begin
                n_fail++; $display("FAIL count_ch%0d: got %0d expected observed %0d model %0d", i, cnt_a[i*TWA +: TWA], obs[i], mdl[i]);
            end
        end
        bus_a.pixel_data  = '0;
        bus_a.pixel_valid = 1'b1;
        @(posedge clk);
        push_image_a('0);
        @(negedge clk);
        bus_a.pixel_valid = 1'b0;
        n_checks++; if (cnt_a !== '0) begin n_fail++; $display("FAIL count_clear: got %h expected 0", cnt_a); end
        repeat (NT + 3) @(posedge clk);
        @(negedge clk);
        sb.delete();
    endtask
`endif

    initial begin
        bus_a.pixel_valid = 1'b0;
        bus_a.pixel_data  = '0;
        bus_b.pixel_valid = 1'b0;
        bus_b.pixel_data  = '0;
        model_reset();
        test_reset();
        test_zero_pix();
        test_mixed();
        test_back_to_back();
        test_reset_midrun();
        test_nt1();
`ifdef SPIKE_ENCODER_COUNT_EN
        test_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
